// File: rtl/add_iss_pkg.sv
// Shared defaults and types for the adder-unit issuer: widths, depths and the
// in-flight pipe entry that carries the expected sum alongside its valid bit.
package add_iss_pkg;

  localparam int W_DEF     = 16;
  localparam int DEPTH_DEF = 4;
  localparam int LAT_DEF   = 2;
  localparam int CNT_W     = $clog2(DEPTH_DEF + 1);

  typedef struct packed {
    logic             v;
    logic [W_DEF-1:0] exp;
  } pipe_entry_t;

endpackage

// File: rtl/add_iss_fifo.sv
// Synchronous result FIFO with occupancy count; a push while full is accepted
// only when a pop frees the head slot at the same edge.
module add_iss_fifo
  import add_iss_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/add_op_issuer.sv
// Issues operand pairs to the pipelined adder unit under a credit limit, tracks
// each op by fixed latency, checks the returned sum and queues it for the consumer.
module add_op_issuer
  import add_iss_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         start,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  input  logic [W-1:0] y,
  input  logic         unit_valid,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_y,
  output logic         err,
  output logic [7:0]   err_cnt,
  output logic         idle
);

  localparam int CW = $clog2(DEPTH + 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  pipe_entry_t   pipe [LAT+1];
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fire;
  logic          capture;
  logic          mismatch;
  int            inflight;

  always_comb begin
    inflight = 0;
    for (int i = 0; i <= LAT; i++) begin
      if (pipe[i].v) inflight = inflight + 1;
    end
  end

  // Credits count results already queued plus ops still travelling through the unit.
  assign in_ready = !rst && ((int'(fifo_count) + inflight) < DEPTH);
  assign fire     = in_valid && in_ready;
  assign idle     = (inflight == 0) && fifo_empty;
  assign capture  = pipe[LAT].v;
  assign mismatch = (y != pipe[LAT].exp) || !unit_valid;

  // Issue register: drives the unit the cycle after acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      start <= 1'b0;
      a     <= '0;
      b     <= '0;
    end else begin
      start <= fire;
      if (fire) begin
        a <= in_a;
        b <= in_b;
      end
    end
  end

  // Latency pipe: stage LAT lines up with the cycle y holds that op's sum
  always_ff @(posedge clk) begin
    pipe[0].exp <= in_a + in_b;
    for (int i = 1; i <= LAT; i++) pipe[i].exp <= pipe[i-1].exp;
    if (rst) begin
      for (int i = 0; i <= LAT; i++) pipe[i].v <= 1'b0;
    end else begin
      pipe[0].v <= fire;
      for (int i = 1; i <= LAT; i++) pipe[i].v <= pipe[i-1].v;
    end
  end

  // Checker: unit_valid is sticky, so it only confirms the unit has ever produced
  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (capture && mismatch) begin
      err     <= 1'b1;
      err_cnt <= sat_inc(err_cnt);
    end
  end

  add_iss_fifo #(
    .W     (W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   (y),
    .pop   (res_ready),
    .dout  (res_y),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign res_valid = !fifo_empty;

endmodule
